icache_axi_refill: RTL and testbench

Line-refill engine sitting directly below the instruction cache on the memory side. It takes a miss request and line address from the cache and issues one 8-beat AXI4 read burst. It collects the beats into a line buffer and pulses `axi_mem_gnt` when the whole line is valid on `ins`. Only the AXI AR/R channels are driven; the write channels belong to other blocks.

---
 rtl/icache_axi_refill.sv | 131 +++++++++++++
 tb/tb_icache_axi_refill.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_refill.sv
// Instruction-cache line refill: one 8-beat AXI4 read burst per miss, collected into a line buffer.
// Build option ICACHE_REFILL_CRITICAL_FIRST_EN: WRAP burst that starts at the missed word.
module icache_axi_refill #(
  parameter int         OFFSET_LEN = 5,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic [31:0]                       addr,
  output logic                              axi_mem_gnt,
  output logic [32*(1<<(OFFSET_LEN-2))-1:0] ins,
  output logic                              resp_err,
  output logic [3:0]                        arid,
  output logic [31:0]                       araddr,
  output logic [7:0]                        arlen,
  output logic [2:0]                        arsize,
  output logic [1:0]                        arburst,
  output logic                              arvalid,
  input  logic                              arready,
  output logic [1:0]                        arlock,
  output logic [3:0]                        arcache,
  output logic [2:0]                        arprot,
  input  logic [3:0]                        rid,
  input  logic [31:0]                       rdata,
  input  logic [1:0]                        rresp,
  input  logic                              rlast,
  input  logic                              rvalid,
  output logic                              rready
);
  localparam int WORDS = 1 << (OFFSET_LEN - 2);
  localparam int IDXW  = OFFSET_LEN - 2;
  localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         araddr_q, araddr_d;
  logic [IDXW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]     widx_q, widx_d;
  logic                err_q, err_d;
  logic [32*WORDS-1:0] ins_q, ins_d;
  logic                beat;
  logic [31:0]         start_addr;
  logic [IDXW-1:0]     start_idx;
  logic                unused_ok;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam logic [1:0] BURST = 2'b10;
  assign start_addr = {addr[31:2], 2'b00};
  assign start_idx  = addr[OFFSET_LEN-1:2];
`else
  localparam logic [1:0] BURST = 2'b01;
  assign start_addr = {addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
  assign start_idx  = '0;
`endif

  assign unused_ok = ^{rid, addr[OFFSET_LEN-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
      cnt_q    <= '0;
      widx_q   <= '0;
      err_q    <= 1'b0;
      ins_q    <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      widx_q   <= widx_d;
      err_q    <= err_d;
      ins_q    <= ins_d;
    end
  end

  assign beat = (state_q == S_R) && rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_AR;
      S_AR:    if (arready) state_d = S_R;
      S_R:     if (beat && cnt_q == LAST_BEAT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completion follows the beat count only; rlast is merely cross-checked into the error flag.
  always_comb begin
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    err_d    = err_q;
    ins_d    = ins_q;
    if (state_q == S_IDLE && req) begin
      araddr_d = start_addr;
      cnt_d    = '0;
      widx_d   = start_idx;
      err_d    = 1'b0;
    end
    if (beat) begin
      for (int i = 0; i < WORDS; i++) begin
        if (widx_q == IDXW'(i)) ins_d[32*i +: 32] = rdata;
      end
      cnt_d  = cnt_q + IDXW'(1);
      widx_d = widx_q + IDXW'(1);
      if (rresp != 2'b00 || rlast != (cnt_q == LAST_BEAT)) err_d = 1'b1;
    end
  end

  always_comb begin
    arvalid     = (state_q == S_AR);
    rready      = (state_q == S_R);
    axi_mem_gnt = (state_q == S_DONE);
  end

  assign araddr   = araddr_q;
  assign ins      = ins_q;
  assign resp_err = err_q;
  assign arid     = AXI_ID;
  assign arlen    = 8'(WORDS - 1);
  assign arsize   = 3'd2;
  assign arburst  = BURST;
  assign arlock   = 2'b00;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: scheduled AXI slave plus a cycle-level expectation model.
`timescale 1ns/1ps
module tb_icache_axi_refill;
  logic         clk = 1'b0;
  logic         rst, req;
  logic [31:0]  addr;
  logic         axi_mem_gnt, resp_err;
  logic [255:0] ins;
  logic [3:0]   arid, arcache, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, arlock, rresp;
  logic         arvalid, arready, rlast, rvalid, rready;

  icache_axi_refill dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .axi_mem_gnt(axi_mem_gnt), .ins(ins),
    .resp_err(resp_err), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam logic [1:0] EXP_BURST = 2'b10;
`else
  localparam logic [1:0] EXP_BURST = 2'b01;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc, done_cyc;

  // expectation model: what the outputs must show during the current cycle
  logic        chk_en = 1'b0;
  logic        exp_arvalid, exp_rready, exp_gnt, exp_err, chk_err, post_rst;
  logic [31:0] exp_araddr;
  logic [31:0] exp_ins [8];

  // per-refill stimulus plan
  logic [31:0] beat_data [8];
  logic [1:0]  beat_resp [8];
  int          ar_stall, gap_mode, rlast_pos, rst_after;
  logic        junk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("arvalid", 32'(arvalid), 32'(exp_arvalid));
      chk("rready", 32'(rready), 32'(exp_rready));
      chk("axi_mem_gnt", 32'(axi_mem_gnt), 32'(exp_gnt));
      chk("ar_tieoffs", {23'b0, arlock, arcache, arprot}, 32'd0);
      if (exp_arvalid) begin
        chk("araddr", araddr, exp_araddr);
        chk("arlen", 32'(arlen), 32'd7);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'(EXP_BURST));
        chk("arid", 32'(arid), 32'd0);
      end
      if (post_rst) chk("araddr_rst", araddr, 32'd0);
      if (chk_err) chk("resp_err", 32'(resp_err), 32'(exp_err));
      for (int i = 0; i < 8; i++) chk($sformatf("ins[%0d]", i), ins[32*i +: 32], exp_ins[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic plan_default();
    ar_stall = 0; gap_mode = 0; rlast_pos = 7; rst_after = -1; junk_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat_data[i] = $urandom;
      beat_resp[i] = 2'b00;
    end
  endtask

  task automatic drive_junk();
    if (junk_en) begin
      rvalid = 1'($urandom); rdata = $urandom; rresp = 2'($urandom); rlast = 1'($urandom);
    end else begin
      rvalid = 1'b0;
    end
  endtask

  task automatic run_refill(input logic [31:0] a);
    int  b, idx0;
    logic give, tog;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    idx0 = int'(a[4:2]);
`else
    idx0 = 0;
`endif
    cyc = 0; req = 1'b1; addr = a; arready = 1'b0; rvalid = 1'b0;
    tick();
    exp_arvalid = 1'b1; exp_err = 1'b0; chk_err = 1'b1;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    exp_araddr = a & 32'hFFFF_FFFC;
`else
    exp_araddr = a & 32'hFFFF_FFE0;
`endif
    for (int s = 0; s < ar_stall; s++) begin
      arready = 1'b0; drive_junk(); tick();
    end
    arready = 1'b1; drive_junk(); tick();
    arready = 1'b0; exp_arvalid = 1'b0; exp_rready = 1'b1; chk_err = 1'b0;
    b = 0; tog = 1'b1;
    while (b < 8) begin
      if (rst_after == b) begin
        rst = 1'b1; rvalid = 1'b0; tick();
        rst = 1'b0; req = 1'b0;
        exp_rready = 1'b0; exp_gnt = 1'b0; exp_err = 1'b0; chk_err = 1'b1; post_rst = 1'b1;
        for (int i = 0; i < 8; i++) exp_ins[i] = 32'd0;
        tick();
        post_rst = 1'b0; chk_err = 1'b0;
        return;
      end
      if (gap_mode == 0)      give = 1'b1;
      else if (gap_mode == 1) begin give = tog; tog = ~tog; end
      else                    give = ($urandom_range(0, 2) != 0);
      if (give) begin
        rvalid = 1'b1; rdata = beat_data[b]; rresp = beat_resp[b];
        rlast = (b == rlast_pos); rid = 4'($urandom);
      end else begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom); rlast = 1'($urandom);
      end
      tick();
      if (give) begin
        exp_ins[(idx0 + b) % 8] = beat_data[b];
        if (beat_resp[b] != 2'b00 || ((b == rlast_pos) != (b == 7))) exp_err = 1'b1;
        b++;
      end
    end
    rvalid = 1'b0; req = 1'b0;
    exp_rready = 1'b0; exp_gnt = 1'b1; chk_err = 1'b1; done_cyc = cyc;
    tick();
    exp_gnt = 1'b0; chk_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; arready = 1'b0; rvalid = 1'b0;
    rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    exp_arvalid = 1'b0; exp_rready = 1'b0; exp_gnt = 1'b0; exp_err = 1'b0;
    exp_araddr = '0; chk_err = 1'b1; post_rst = 1'b1;
    for (int i = 0; i < 8; i++) exp_ins[i] = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0; post_rst = 1'b0; chk_err = 1'b0;
    tick();

    // basic refill
    plan_default();
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hA0 + i;
    run_refill(32'h1FC0_0024);
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    chk("pin_araddr", exp_araddr, 32'h1FC0_0024);
    for (int i = 0; i < 8; i++) chk("pin_ins_cf", exp_ins[(i + 1) % 8], 32'hA0 + i);
`else
    chk("pin_araddr", exp_araddr, 32'h1FC0_0020);
    for (int i = 0; i < 8; i++) chk("pin_ins", exp_ins[i], 32'hA0 + i);
`endif
    chk("pin_latency", 32'(done_cyc), 32'd10);

    // backpressure: 3 arready stalls, rvalid alternating
    plan_default();
    ar_stall = 3; gap_mode = 1; junk_en = 1'b1;
    run_refill(32'h0000_4000);
    chk("pin_latency_bp", 32'(done_cyc), 32'd20);

    // wrap ordering address
    plan_default();
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hB0 + i;
    run_refill(32'h0000_1018);
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    chk("pin_wrap_araddr", exp_araddr, 32'h0000_1018);
    chk("pin_wrap_ins6", exp_ins[6], 32'hB0);
    chk("pin_wrap_ins0", exp_ins[0], 32'hB2);
    chk("pin_wrap_ins5", exp_ins[5], 32'hB7);
`else
    chk("pin_wrap_araddr", exp_araddr, 32'h0000_1000);
    chk("pin_wrap_ins6", exp_ins[6], 32'hB6);
`endif

    // error response on beat 4, then a clean refill must clear the flag
    plan_default();
    beat_resp[4] = 2'b10;
    run_refill(32'h0000_2040);
    chk("pin_err", 32'(exp_err), 32'd1);
    chk("pin_latency_err", 32'(done_cyc), 32'd10);
    plan_default();
    run_refill(32'h0000_2060);
    chk("pin_err_clr", 32'(exp_err), 32'd0);

    // misplaced rlast on beat 5, then missing rlast
    plan_default();
    rlast_pos = 5;
    run_refill(32'h0000_3000);
    chk("pin_rlast_early", 32'(exp_err), 32'd1);
    plan_default();
    rlast_pos = -1;
    run_refill(32'h0000_3020);
    chk("pin_rlast_missing", 32'(exp_err), 32'd1);

    // reset after beat 3, then a clean refill
    plan_default();
    rst_after = 4;
    run_refill(32'h0000_5000);
    plan_default();
    run_refill(32'h0000_5020);
    chk("pin_after_rst", 32'(done_cyc), 32'd10);

    // randomized refills, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      plan_default();
      ar_stall = $urandom_range(0, 3);
      gap_mode = $urandom_range(0, 2);
      junk_en  = 1'($urandom);
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 9) == 0) beat_resp[i] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rlast_pos = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) rst_after = $urandom_range(0, 7);
      run_refill($urandom);
      repeat ($urandom_range(0, 2)) tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
